// File: rtl/store_trace_buffer.sv
// store_trace_buffer: captures processor stores ({dataadr, writedata}) into a
// circular FIFO once armed. A store that finds the buffer full with no
// same-edge pop is dropped, sets the sticky overflow flag and freezes capture.
// The consumer can drain the buffer in any state.
//
// Optional feature: define STORE_TRACE_DROPCNT_EN to add a 16-bit saturating
// drop_count output. It counts the store that caused the freeze plus every
// store that arrives while frozen.
module store_trace_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  input  logic                     arm,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               state
`ifdef STORE_TRACE_DROPCNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    FROZEN = 2'b10
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic            overflow_q;

  logic            full;
  logic            nonempty;
  logic            push;
  logic            pop;
  logic            drop;

  assign full     = (count_q == CW'(DEPTH));
  assign nonempty = (count_q != '0);

  // Push/pop/drop qualification; clr overrides every other action.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (!clr) begin
      pop = nonempty && out_ready;
      if (state_q == ARMED && memwrite) begin
        // A pop on the same edge frees a slot, so a full buffer still accepts.
        push = !full || pop;
        drop = full && !pop;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; arm only matters in IDLE.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm)  state_d = ARMED;
        ARMED:   if (drop) state_d = FROZEN;
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (clr) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag, set by a dropped store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (clr) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  // Trace storage; contents are not reset, emptiness is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {dataadr, writedata};
    end
  end

`ifdef STORE_TRACE_DROPCNT_EN
  logic [15:0] drop_cnt_q;
  logic        drop_evt;

  assign drop_evt = drop || (!clr && state_q == FROZEN && memwrite);

  // Saturating count of stores lost to the freeze.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (clr) begin
      drop_cnt_q <= '0;
    end else if (drop_evt && drop_cnt_q != '1) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  // Head entry is forced to zero when empty so stale storage never leaks out.
  assign out_valid = nonempty;
  assign out_data  = nonempty ? mem[rd_ptr] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign state     = state_q;

endmodule

// File: tb/tb_store_trace_buffer.sv
// Self-checking bench for store_trace_buffer (DEPTH=16) against a queue model.
module tb_store_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        arm;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  count;
  logic        overflow;
  logic [1:0]  state;
`ifdef STORE_TRACE_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: queue of entries, state as 0/1/2, sticky flag, drop tally.
  logic [63:0] mq[$];
  int          mstate;
  bit          movf;
  int          mdrop;

  store_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .arm       (arm),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .state     (state)
`ifdef STORE_TRACE_DROPCNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_head();
    if (mq.size() != 0) return mq[0];
    return 64'h0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    mstate = 0;
    movf   = 1'b0;
    mdrop  = 0;
  endfunction

  // Apply one clock edge to the model from current inputs, then advance the DUT.
  task automatic tick();
    int old;
    bit pop;
    old = mstate;
    if (clr) begin
      model_reset();
    end else begin
      pop = (mq.size() != 0) && out_ready;
      if (old == 1 && memwrite) begin
        if (mq.size() < DEPTH || pop) mq.push_back({dataadr, writedata});
        else begin
          movf   = 1'b1;
          mstate = 2;
          if (mdrop < 65535) mdrop++;
        end
      end else if (old == 2 && memwrite) begin
        if (mdrop < 65535) mdrop++;
      end
      if (pop) void'(mq.pop_front());
      if (old == 0 && arm) mstate = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memwrite = 1'b0; arm = 1'b0; clr = 1'b0; out_ready = 1'b0;
    dataadr = '0; writedata = '0;
  endtask

  task automatic restart_armed();
    idle_inputs();
    clr = 1'b1; tick();
    clr = 1'b0; arm = 1'b1; tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %0b want 00", state); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
`ifdef STORE_TRACE_DROPCNT_EN
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_dropcnt got %0d want 0", drop_count); end
`endif
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    // arm and store on the same edge in IDLE: store must not be captured
    arm = 1'b1; memwrite = 1'b1; dataadr = 32'h99; writedata = 32'h1; tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL arm_state got %0b want 01", state); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL arm_store_count got %0d want 0", count); end
    arm = 1'b0; out_ready = 1'b1;
    dataadr = 32'h54; writedata = 32'h7; tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 64'h00000054_00000007) begin errors++; $display("FAIL basic_first got %h want 0000005400000007", out_data); end
    dataadr = 32'h50; writedata = 32'h7; tick();
    checks++; if (out_data !== 64'h00000050_00000007) begin errors++; $display("FAIL basic_second got %h want 0000005000000007", out_data); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL basic_count1 got %0d want 1", count); end
    memwrite = 1'b0; tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL basic_drain got %0d want 0", count); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL basic_empty_data got %h want 0", out_data); end
  endtask

  task automatic test_overflow();
    restart_armed();
    for (int i = 0; i < 17; i++) begin
      memwrite = 1'b1; dataadr = i; writedata = $urandom; tick();
    end
    memwrite = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL ovf_state got %0b want 10", state); end
`ifdef STORE_TRACE_DROPCNT_EN
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovf_dropcnt got %0d want 1", drop_count); end
`endif
    // a store while frozen is neither captured nor otherwise visible except in drop tally
    memwrite = 1'b1; dataadr = 32'hDEAD; tick();
    memwrite = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL frozen_store_count got %0d want 16", count); end
`ifdef STORE_TRACE_DROPCNT_EN
    checks++; if (drop_count !== 16'(mdrop)) begin errors++; $display("FAIL frozen_dropcnt got %0d want %0d", drop_count, mdrop); end
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_data !== model_head() || out_data[63:32] !== 32'(i)) begin
        errors++; $display("FAIL ovf_entry%0d got %h want %h", i, out_data, model_head());
      end
      tick();
    end
    checks++; if (count !== 5'd0 || state !== 2'b10) begin errors++; $display("FAIL ovf_drain got count %0d state %0b want 0 10", count, state); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    restart_armed();
    for (int i = 0; i < 16; i++) begin
      memwrite = 1'b1; dataadr = 32'h200 + i; writedata = $urandom; tick();
    end
    memwrite = 1'b1; out_ready = 1'b1; dataadr = 32'h100; writedata = 32'hABCD; tick();
    memwrite = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_pp_count got %0d want 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pp_ovf got %0b want 0", overflow); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL full_pp_state got %0b want 01", state); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_data !== model_head()) begin errors++; $display("FAIL full_pp_entry%0d got %h want %h", i, out_data, model_head()); end
      if (i == 15) begin
        checks++;
        if (out_data !== 64'h00000100_0000ABCD) begin errors++; $display("FAIL full_pp_last got %h want 000001000000abcd", out_data); end
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int nxt;
    nxt = 0;
    restart_armed();
    for (int i = 0; i < 60; i++) begin
      memwrite = (i < 40); dataadr = i; writedata = ~32'(i);
      out_ready = (i % 4 != 0);
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== {32'(nxt), ~32'(nxt)}) begin
          errors++; $display("FAIL wrap_order got %h want %h", out_data, {32'(nxt), ~32'(nxt)});
        end
        nxt++;
      end
      tick();
    end
    out_ready = 1'b0; memwrite = 1'b0;
    checks++; if (nxt != 40 || count !== 5'd0) begin errors++; $display("FAIL wrap_total got %0d popped count %0d want 40 0", nxt, count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %0b want 0", overflow); end
  endtask

  task automatic test_clr();
    restart_armed();
    for (int i = 0; i < 5; i++) begin
      memwrite = 1'b1; dataadr = i; writedata = $urandom; tick();
    end
    clr = 1'b1; memwrite = 1'b1; dataadr = 32'h77; tick();
    clr = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL clr_count got %0d want 0", count); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL clr_state got %0b want 00", state); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b want 0", out_valid); end
    tick();
    memwrite = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL idle_store_count got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    restart_armed();
    for (int i = 0; i < 3; i++) begin
      memwrite = 1'b1; dataadr = i; writedata = $urandom; tick();
    end
    memwrite = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %0b want 0", out_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL async_count got %0d want 0", count); end
    checks++; if (state !== 2'b00 || out_data !== 64'h0) begin errors++; $display("FAIL async_state got %0b data %h want 00 0", state, out_data); end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    restart_armed();
    for (int i = 0; i < 1500; i++) begin
      memwrite  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 4);
      arm       = ($urandom_range(0, 7) == 0);
      clr       = ($urandom_range(0, 63) == 0);
      dataadr   = $urandom;
      writedata = $urandom;
      tick();
      checks++;
      if (count !== 5'(mq.size()) || out_valid !== (mq.size() != 0) || out_data !== model_head() ||
          overflow !== movf || state !== 2'(mstate)) begin
        errors++;
        $display("FAIL rand_cycle%0d got cnt=%0d v=%0b d=%h ovf=%0b st=%0b want cnt=%0d v=%0b d=%h ovf=%0b st=%0d",
                 i, count, out_valid, out_data, overflow, state, mq.size(), mq.size() != 0, model_head(), movf, mstate);
      end
`ifdef STORE_TRACE_DROPCNT_EN
      checks++;
      if (drop_count !== 16'(mdrop)) begin errors++; $display("FAIL rand_dropcnt%0d got %0d want %0d", i, drop_count, mdrop); end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_clr();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
